basic_and_bist: RTL and testbench
=================================

BASIC_AND_BIST -- requirements
Module: basic_and_bist

Interface
- REQ-001 The parameters SHALL be:
  - WIDTH, default 4: operand width of the bitwise-AND unit under test.
  - ERR_W, default 16: width of the error counter.
- REQ-002 clk  input  1  single system clock; all logic is rising-edge.
- REQ-003 rst  input  1  reset, synchronous and active-high.
- REQ-004 start  input  1  run request, sampled only in IDLE and DONE.
- REQ-005 dut_a  output  WIDTH  operand A driven to the external AND unit.
- REQ-006 dut_b  output  WIDTH  operand B driven to the external AND unit.
- REQ-007 dut_out  input  WIDTH  combinational result returned by the AND unit.
- REQ-008 busy  output  1  high while in RUN.
- REQ-009 done  output  1  high while in DONE.
- REQ-010 pass  output  1  valid when done; high iff the error count is 0.
- REQ-011 err_count  output  ERR_W  number of mismatching vectors, saturating.

Function
- REQ-012 The FSM SHALL have states IDLE, RUN and DONE; rst forces IDLE.
- REQ-013 IDLE transitions:
  - start=1 -> RUN on the next edge;
  - the 2*WIDTH-bit vector counter, err_count and the capture registers clear on that edge.
- REQ-014 Vector mapping: {dut_a,dut_b} = vector counter, dut_a in the high half; both are registered outputs.
- REQ-015 Vector k SHALL be driven for exactly one RUN cycle.
- REQ-016 At the edge ending that cycle, dut_out SHALL be compared with dut_a & dut_b.
- REQ-017 On a mismatch, err_count SHALL increment, holding at 2^ERR_W-1 once saturated.
- REQ-018 The counter SHALL increment every RUN cycle. The compare of vector 2^(2*WIDTH)-1 SHALL move the FSM to DONE, with the counter wrapping to 0.
- REQ-019 RUN SHALL last exactly 2^(2*WIDTH) cycles, so done rises 2^(2*WIDTH)+1 edges after the edge that sampled start.
- REQ-020 start SHALL be ignored in RUN.
- REQ-021 In DONE, done, pass and err_count SHALL hold. start=1 -> RUN with a fresh clear, as from IDLE.
- REQ-022 busy and done SHALL be decoded directly from the state register, with no extra latency.
- REQ-023 pass SHALL be 0 outside DONE.

Reset
- REQ-024 Synchronous rst SHALL force the following on the next edge, including mid-RUN, where the partial result is discarded:
  - state IDLE;
  - dut_a=0, dut_b=0, counter=0;
  - err_count=0, busy=0, done=0, pass=0;
  - capture registers=0.

Configuration
- REQ-025 With BASIC_AND_BIST_FAIL_CAPTURE_EN defined, the block SHALL add:
  - outputs fail_a[WIDTH], fail_b[WIDTH] and fail_out[WIDTH];
  - flag fail_valid.
- REQ-026 With the macro defined, the first mismatch of a run SHALL latch its vector and received dut_out and set fail_valid. Later mismatches SHALL not overwrite them.
- REQ-027 With the macro undefined, none of these ports or registers SHALL exist, and behaviour is otherwise identical.

Structure
- REQ-028 A shared package basic_and_bist_pkg SHALL hold:
  - the state encoding typedef (IDLE=0, RUN=1, DONE=2);
  - the default WIDTH/ERR_W constants.
- REQ-029 The compare/saturating-count datapath SHALL be the one sub-module, basic_and_bist_cmp. The FSM and vector counter stay in the top.

Verification (WIDTH=4, ERR_W=16 unless stated)
- REQ-030 Correct AND model, 1-cycle start pulse:
  - busy for 256 cycles;
  - done rises 257 edges after start;
  - pass=1, err_count=0.
- REQ-031 dut_out[0] stuck at 0:
  - err_count=64, pass=0;
  - fail_a=0001, fail_b=0001, fail_out=0000, fail_valid=1.
- REQ-032 dut_out[3] stuck at 1:
  - err_count=192;
  - first capture fail_a=0000, fail_b=0000, fail_out=1000.
- REQ-033 ERR_W=4 with the dut_out[0] stuck-at-0 fault -> err_count saturates at 15, pass=0.
- REQ-034 rst pulsed when the counter=100:
  - all outputs 0, state IDLE on the next edge;
  - a subsequent start completes normally with pass=1.
- REQ-035 start held high through RUN and DONE:
  - done asserts for exactly one cycle at edge 257;
  - RUN then restarts with err_count cleared.

Source files
------------

// File: rtl/basic_and_bist_pkg.sv
// Shared definitions for the exhaustive bitwise-AND BIST.
//   state_t      : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DEF_WIDTH    : default operand width
//   DEF_ERR_W    : default error counter width
package basic_and_bist_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ERR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/basic_and_bist_cmp.sv
// Compare and saturating error count datapath for the AND BIST.
//   clk, rst       : system clock, synchronous active-high reset
//   clear          : start of a new run, clears count and capture
//   en             : high during RUN cycles, enables the compare
//   a, b           : operands currently driven to the AND unit
//   res            : result returned by the AND unit
//   err_count      : number of mismatches, saturating at all-ones
// Optional (BASIC_AND_BIST_FAIL_CAPTURE_EN): fail_a, fail_b, fail_out and
// fail_valid hold the first mismatching vector of the run.
module basic_and_bist_cmp #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] res,
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_out,
    output logic             fail_valid,
`endif
    output logic [ERR_W-1:0] err_count
);

    logic mismatch;

    assign mismatch = en && (res != (a & b));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count <= '0;
        end else if (mismatch && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
    // Only the first mismatch of a run is kept.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail_a     <= '0;
            fail_b     <= '0;
            fail_out   <= '0;
            fail_valid <= 1'b0;
        end else if (mismatch && !fail_valid) begin
            fail_a     <= a;
            fail_b     <= b;
            fail_out   <= res;
            fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/basic_and_bist.sv
// Exhaustive BIST for an external WIDTH-bit bitwise-AND unit. Every
// {dut_a,dut_b} combination is driven for one cycle and the returned
// result is checked against a & b.
//   clk, rst          : system clock, synchronous active-high reset
//   start             : run request (honoured in IDLE and DONE only)
//   dut_a, dut_b      : registered operands to the AND unit
//   dut_out           : combinational result from the AND unit
//   busy, done, pass  : status (pass valid only while done)
//   err_count         : saturating mismatch count
// Optional macro BASIC_AND_BIST_FAIL_CAPTURE_EN adds fail_a, fail_b,
// fail_out and fail_valid (first mismatch of the run).
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | sweeping all 2^(2*WIDTH) vectors, one per cycle
// DONE  | sweep finished, results held until next start
module basic_and_bist
    import basic_and_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_out,
    output logic             fail_valid,
`endif
    output logic [ERR_W-1:0] err_count
);

    state_t               state_q;
    state_t               state_d;
    logic                 start_run;
    logic [2*WIDTH-1:0]   vec_q;
    logic                 last_vec;

    assign last_vec = (vec_q == '1);

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (last_vec) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter wraps to 0 on the final compare, so DONE drives zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_run) begin
                vec_q <= '0;
            end else if (state_q == RUN) begin
                vec_q <= vec_q + 1'b1;
            end
        end
    end

    assign {dut_a, dut_b} = vec_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_count == '0);

    basic_and_bist_cmp #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_run),
        .en         (busy),
        .a          (dut_a),
        .b          (dut_b),
        .res        (dut_out),
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_out   (fail_out),
        .fail_valid (fail_valid),
`endif
        .err_count  (err_count)
    );

endmodule

// File: tb/tb_basic_and_bist.sv
module tb_basic_and_bist;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  dut_a, dut_b, dut_out;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [1:0]  fault;          // 0 none, 1 out[0] stuck 0, 2 out[3] stuck 1
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
    logic [3:0]  fail_a, fail_b, fail_out;
    logic        fail_valid;
    logic [3:0]  fail_a4, fail_b4, fail_out4;
    logic        fail_valid4;
`endif

    // Second instance: ERR_W=4, permanently faulted with out[0] stuck at 0.
    logic [3:0]  dut_a4, dut_b4, dut_out4;
    logic        busy4, done4, pass4;
    logic [3:0]  err_count4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        dut_out = dut_a & dut_b;
        if (fault == 2'd1) dut_out[0] = 1'b0;
        if (fault == 2'd2) dut_out[3] = 1'b1;
        dut_out4 = (dut_a4 & dut_b4) & 4'b1110;
    end

    basic_and_bist #(.WIDTH(4), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass),
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
        .fail_a(fail_a), .fail_b(fail_b), .fail_out(fail_out), .fail_valid(fail_valid),
`endif
        .err_count(err_count)
    );

    basic_and_bist #(.WIDTH(4), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(dut_a4), .dut_b(dut_b4), .dut_out(dut_out4),
        .busy(busy4), .done(done4), .pass(pass4),
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
        .fail_a(fail_a4), .fail_b(fail_b4), .fail_out(fail_out4), .fail_valid(fail_valid4),
`endif
        .err_count(err_count4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns busy cycle count and the edge
    // (sampling edge = 1) after which done was first seen.
    task automatic run_full(output int busy_cnt, output int done_edge);
        busy_cnt  = 0;
        done_edge = 0;
        start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            step();
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_edge = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; fault = 2'd0;
        step(); step();
        n_cmp++;
        if ({busy, done, pass} !== 3'b000) begin
            n_bad++; $display("FAIL reset_status: got %b need 000", {busy, done, pass});
        end
        n_cmp++;
        if ({dut_a, dut_b, err_count} !== 24'd0) begin
            n_bad++; $display("FAIL reset_data: got a=%h b=%h err=%0d need 0", dut_a, dut_b, err_count);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold: got busy=%b done=%b need 0 0", busy, done);
        end
    endtask

    task automatic test_good();
        int bc, de;
        fault = 2'd0;
        run_full(bc, de);
        n_cmp++;
        if (bc !== 256) begin n_bad++; $display("FAIL good_busy_cycles: got %0d need 256", bc); end
        n_cmp++;
        if (de !== 257) begin n_bad++; $display("FAIL good_done_edge: got %0d need 257", de); end
        n_cmp++;
        if (pass !== 1'b1 || err_count !== 16'd0) begin
            n_bad++; $display("FAIL good_result: got pass=%b err=%0d need 1 0", pass, err_count);
        end
        n_cmp++;
        if (dut_a !== 4'd0 || dut_b !== 4'd0) begin
            n_bad++; $display("FAIL good_wrap: got a=%h b=%h need 0 0", dut_a, dut_b);
        end
        step(); step();
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL done_hold: got done=%b pass=%b busy=%b need 1 1 0", done, pass, busy);
        end
    endtask

    task automatic test_stuck0();
        int bc, de;
        fault = 2'd1;
        run_full(bc, de);
        n_cmp++;
        if (de !== 257) begin n_bad++; $display("FAIL s0_done_edge: got %0d need 257", de); end
        n_cmp++;
        if (err_count !== 16'd64 || pass !== 1'b0) begin
            n_bad++; $display("FAIL s0_result: got err=%0d pass=%b need 64 0", err_count, pass);
        end
        n_cmp++;
        if (err_count4 !== 4'd15 || pass4 !== 1'b0 || done4 !== 1'b1) begin
            n_bad++; $display("FAIL s0_saturate: got err=%0d pass=%b done=%b need 15 0 1", err_count4, pass4, done4);
        end
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
        n_cmp++;
        if ({fail_valid, fail_a, fail_b, fail_out} !== {1'b1, 4'b0001, 4'b0001, 4'b0000}) begin
            n_bad++; $display("FAIL s0_capture: got v=%b a=%b b=%b o=%b need 1 0001 0001 0000",
                              fail_valid, fail_a, fail_b, fail_out);
        end
`endif
    endtask

    task automatic test_stuck1();
        int bc, de;
        fault = 2'd2;
        run_full(bc, de);
        n_cmp++;
        if (err_count !== 16'd192 || pass !== 1'b0 || de !== 257) begin
            n_bad++; $display("FAIL s1_result: got err=%0d pass=%b edge=%0d need 192 0 257", err_count, pass, de);
        end
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
        n_cmp++;
        if ({fail_valid, fail_a, fail_b, fail_out} !== {1'b1, 4'b0000, 4'b0000, 4'b1000}) begin
            n_bad++; $display("FAIL s1_capture: got v=%b a=%b b=%b o=%b need 1 0000 0000 1000",
                              fail_valid, fail_a, fail_b, fail_out);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int bc, de;
        fault = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 2; n <= 101; n++) step();
        n_cmp++;
        if ({dut_a, dut_b} !== 8'd100 || busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_vector: got vec=%0d busy=%b need 100 1", {dut_a, dut_b}, busy);
        end
        n_cmp++;
        if (err_count !== 16'd24) begin
            n_bad++; $display("FAIL mid_errs: got %0d need 24", err_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, pass, dut_a, dut_b, err_count} !== 27'd0) begin
            n_bad++; $display("FAIL mid_reset: got busy=%b done=%b pass=%b a=%h b=%h err=%0d need all 0",
                              busy, done, pass, dut_a, dut_b, err_count);
        end
`ifdef BASIC_AND_BIST_FAIL_CAPTURE_EN
        n_cmp++;
        if ({fail_valid, fail_a, fail_b, fail_out} !== 13'd0) begin
            n_bad++; $display("FAIL mid_reset_capture: got v=%b a=%b b=%b o=%b need 0",
                              fail_valid, fail_a, fail_b, fail_out);
        end
`endif
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL mid_idle: got busy=%b done=%b need 0 0", busy, done);
        end
        fault = 2'd0;
        run_full(bc, de);
        n_cmp++;
        if (pass !== 1'b1 || de !== 257 || bc !== 256) begin
            n_bad++; $display("FAIL mid_rerun: got pass=%b edge=%0d busy=%0d need 1 257 256", pass, de, bc);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int done_at;
        fault    = 2'd1;
        done_cnt = 0;
        done_at  = 0;
        start    = 1'b1;
        for (int n = 1; n <= 258; n++) begin
            step();
            if (done) begin
                done_cnt++;
                done_at = n;
                n_cmp++;
                if (err_count !== 16'd64) begin
                    n_bad++; $display("FAIL b2b_err_at_done: got %0d need 64", err_count);
                end
            end
        end
        n_cmp++;
        if (done_cnt !== 1 || done_at !== 257) begin
            n_bad++; $display("FAIL b2b_done_pulse: got count=%0d edge=%0d need 1 257", done_cnt, done_at);
        end
        n_cmp++;
        if (busy !== 1'b1 || err_count !== 16'd0 || pass !== 1'b0) begin
            n_bad++; $display("FAIL b2b_restart: got busy=%b err=%0d pass=%b need 1 0 0", busy, err_count, pass);
        end
        step();
        n_cmp++;
        if (busy !== 1'b1 || {dut_a, dut_b} !== 8'd1) begin
            n_bad++; $display("FAIL b2b_running: got busy=%b vec=%0d need 1 1", busy, {dut_a, dut_b});
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good();
        test_stuck0();
        test_stuck1();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
